// File: rtl/axi_lite_reg_slave_if.sv
// AXI-lite bus bundle between a master and axi_lite_reg_slave.
// BLEN rides with the AR channel and sets the read burst length (BLEN+1 beats).
interface axi_lite_reg_slave_if;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  BLEN;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RLAST;
  logic        RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, BLEN, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID, RLAST
  );
  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, BLEN, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID, RLAST
  );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI-lite register-file slave: independent write FSM (AW/W in any order, B response)
// and burst read FSM (BLEN+1 beats, RLAST, SLVERR past the last register).
module axi_lite_reg_slave #(
  parameter int NREG  = 16,
  parameter int LED_W = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  axi_lite_reg_slave_if.slave  bus,
  output logic [LED_W-1:0]     led
);
  localparam int          IW     = $clog2(NREG);
  localparam logic [30:0] NREG_W = 31'(NREG);

  typedef enum logic [1:0] {WR_IDLE, WR_WAIT_W, WR_WAIT_AW, WR_RESP} wr_st_t;
  typedef enum logic       {RD_IDLE, RD_DATA} rd_st_t;

  logic [31:0] r_regs [NREG];

  wr_st_t      r_wst, w_wst_nxt;
  logic [29:0] r_awidx;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_bresp;
  logic        w_commit, w_lat_aw, w_lat_w, w_cok;
  logic [29:0] w_cidx;
  logic [31:0] w_cdata;
  logic [3:0]  w_cstrb;

  rd_st_t      r_rst, w_rst_nxt;
  logic [30:0] r_ridx, w_lidx;
  logic [3:0]  r_beats, w_lbeats;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        r_rlast, w_load, w_rdone;

  logic        w_unused;
  assign w_unused = ^{bus.AWADDR[1:0], bus.ARADDR[1:0]};

  // Commit operands come from the bus unless that half was latched earlier.
  always_comb begin
    w_wst_nxt   = r_wst;
    w_commit    = 1'b0;
    w_lat_aw    = 1'b0;
    w_lat_w     = 1'b0;
    w_cidx      = bus.AWADDR[31:2];
    w_cdata     = bus.WDATA;
    w_cstrb     = bus.WSTRB;
    bus.AWREADY = 1'b0;
    bus.WREADY  = 1'b0;
    bus.BVALID  = 1'b0;
    case (r_wst)
      WR_IDLE: begin
        bus.AWREADY = 1'b1;
        bus.WREADY  = 1'b1;
        if (bus.AWVALID && bus.WVALID) begin
          w_commit  = 1'b1;
          w_wst_nxt = WR_RESP;
        end else if (bus.AWVALID) begin
          w_lat_aw  = 1'b1;
          w_wst_nxt = WR_WAIT_W;
        end else if (bus.WVALID) begin
          w_lat_w   = 1'b1;
          w_wst_nxt = WR_WAIT_AW;
        end
      end
      WR_WAIT_W: begin
        bus.WREADY = 1'b1;
        w_cidx     = r_awidx;
        if (bus.WVALID) begin
          w_commit  = 1'b1;
          w_wst_nxt = WR_RESP;
        end
      end
      WR_WAIT_AW: begin
        bus.AWREADY = 1'b1;
        w_cdata     = r_wdata;
        w_cstrb     = r_wstrb;
        if (bus.AWVALID) begin
          w_commit  = 1'b1;
          w_wst_nxt = WR_RESP;
        end
      end
      default: begin
        bus.BVALID = 1'b1;
        if (bus.BREADY) w_wst_nxt = WR_IDLE;
      end
    endcase
  end

  assign w_cok     = ({1'b0, w_cidx} < NREG_W);
  assign bus.BRESP = r_bresp;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wst   <= WR_IDLE;
      r_awidx <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_bresp <= 2'b00;
    end else begin
      r_wst <= w_wst_nxt;
      if (w_lat_aw) r_awidx <= bus.AWADDR[31:2];
      if (w_lat_w) begin
        r_wdata <= bus.WDATA;
        r_wstrb <= bus.WSTRB;
      end
      if (w_commit) r_bresp <= w_cok ? 2'b00 : 2'b10;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_commit && w_cok) begin
      for (int b = 0; b < 4; b++)
        if (w_cstrb[b]) r_regs[w_cidx[IW-1:0]][8*b +: 8] <= w_cdata[8*b +: 8];
    end
  end

  assign led = r_regs[0][LED_W-1:0];

  // A beat is loaded on the AR handshake and on every non-final R handshake.
  always_comb begin
    w_rst_nxt   = r_rst;
    w_load      = 1'b0;
    w_rdone     = 1'b0;
    w_lidx      = {1'b0, bus.ARADDR[31:2]};
    w_lbeats    = bus.BLEN;
    bus.ARREADY = 1'b0;
    bus.RVALID  = 1'b0;
    case (r_rst)
      RD_IDLE: begin
        bus.ARREADY = 1'b1;
        if (bus.ARVALID) begin
          w_load    = 1'b1;
          w_rst_nxt = RD_DATA;
        end
      end
      default: begin
        bus.RVALID = 1'b1;
        if (bus.RREADY) begin
          if (r_rlast) begin
            w_rdone   = 1'b1;
            w_rst_nxt = RD_IDLE;
          end else begin
            w_load   = 1'b1;
            w_lidx   = r_ridx + 31'd1;
            w_lbeats = r_beats - 4'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rst   <= RD_IDLE;
      r_ridx  <= '0;
      r_beats <= '0;
      r_rdata <= '0;
      r_rresp <= 2'b00;
      r_rlast <= 1'b0;
    end else begin
      r_rst <= w_rst_nxt;
      if (w_load) begin
        r_ridx  <= w_lidx;
        r_beats <= w_lbeats;
        r_rlast <= (w_lbeats == 4'd0);
        if (w_lidx < NREG_W) begin
          r_rdata <= r_regs[w_lidx[IW-1:0]];
          r_rresp <= 2'b00;
        end else begin
          r_rdata <= '0;
          r_rresp <= 2'b10;
        end
      end else if (w_rdone) begin
        r_rlast <= 1'b0;
      end
    end
  end

  assign bus.RDATA = r_rdata;
  assign bus.RRESP = r_rresp;
  assign bus.RLAST = r_rlast;
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave; a negedge monitor scores B and R handshakes
// against queues of expected responses pushed by the stimulus.
module tb_axi_lite_reg_slave;
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic [15:0] led;

  axi_lite_reg_slave_if bus();

  axi_lite_reg_slave #(.NREG(16), .LED_W(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .bus(bus), .led(led)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
  } rexp_t;

  logic [1:0] bq [$];
  rexp_t      rq [$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (bus.BVALID && bus.BREADY) begin
        if (bq.size() == 0) chk("b_unexpected", 32'(bq.size()), 32'd1);
        else chk("bresp", 32'(bus.BRESP), 32'(bq.pop_front()));
      end
      if (bus.RVALID && bus.RREADY) begin
        if (rq.size() == 0) chk("r_unexpected", 32'(rq.size()), 32'd1);
        else begin
          rexp_t e;
          e = rq.pop_front();
          chk("rdata", bus.RDATA, e.d);
          chk("rresp", 32'(bus.RRESP), 32'(e.r));
          chk("rlast", 32'(bus.RLAST), 32'(e.l));
        end
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_wr_idle();
    for (int i = 0; i < 50; i++) begin
      if (bus.AWREADY && bus.WREADY) return;
      tick();
    end
    chk("wr_idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rd_idle();
    for (int i = 0; i < 60; i++) begin
      if (bus.ARREADY) return;
      tick();
    end
    chk("rd_idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [1:0] resp);
    wait_wr_idle();
    bq.push_back(resp);
    bus.AWADDR = a; bus.WDATA = d; bus.WSTRB = s;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
  endtask

  task automatic push_r(input logic [31:0] d, input logic [1:0] r, input logic l);
    rexp_t e;
    e.d = d; e.r = r; e.l = l;
    rq.push_back(e);
  endtask

  task automatic issue_ar(input logic [31:0] a, input logic [3:0] blen);
    wait_rd_idle();
    bus.ARADDR = a; bus.BLEN = blen; bus.ARVALID = 1'b1;
    tick();
    bus.ARVALID = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_awready"}, 32'(bus.AWREADY), 32'd1);
    chk({tag, "_wready"},  32'(bus.WREADY),  32'd1);
    chk({tag, "_arready"}, 32'(bus.ARREADY), 32'd1);
    chk({tag, "_bvalid"},  32'(bus.BVALID),  32'd0);
    chk({tag, "_bresp"},   32'(bus.BRESP),   32'd0);
    chk({tag, "_rvalid"},  32'(bus.RVALID),  32'd0);
    chk({tag, "_rlast"},   32'(bus.RLAST),   32'd0);
    chk({tag, "_rresp"},   32'(bus.RRESP),   32'd0);
    chk({tag, "_rdata"},   bus.RDATA,        32'd0);
    chk({tag, "_led"},     32'(led),         32'd0);
  endtask

  initial begin
    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b1; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.BLEN = '0; bus.RREADY = 1'b1;
    repeat (3) tick();
    chk_reset_outs("rst");
    ARESET = 1'b0;
    tick();

    // AW and W together
    write(32'h0, 32'h0000_A5A5, 4'hF, 2'b00);
    chk("b_next_cycle", 32'(bus.BVALID), 32'd1);
    chk("led_a5a5", 32'(led), 32'h0000_A5A5);
    tick();

    // W two cycles ahead of AW, with B backpressure
    write(32'h8, 32'hFFFF_FFFF, 4'hF, 2'b00);
    wait_wr_idle();
    bus.BREADY = 1'b0;
    bus.WDATA = 32'h1234_5678; bus.WSTRB = 4'b0101; bus.WVALID = 1'b1;
    tick();
    bus.WVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("waw_awready", 32'(bus.AWREADY), 32'd1);
      chk("waw_wready", 32'(bus.WREADY), 32'd0);
      tick();
    end
    bq.push_back(2'b00);
    bus.AWADDR = 32'h8; bus.AWVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bhold_bvalid", 32'(bus.BVALID), 32'd1);
      chk("bhold_bresp", 32'(bus.BRESP), 32'd0);
      chk("bhold_awready", 32'(bus.AWREADY), 32'd0);
      tick();
    end
    bus.BREADY = 1'b1;
    tick();
    push_r(32'hFF34_FF78, 2'b00, 1'b1);
    issue_ar(32'h8, 4'd0);
    wait_rd_idle();

    // 4-beat burst with no bubbles
    write(32'h0, 32'h10, 4'hF, 2'b00);
    write(32'h4, 32'h11, 4'hF, 2'b00);
    write(32'h8, 32'h12, 4'hF, 2'b00);
    write(32'hC, 32'h13, 4'hF, 2'b00);
    wait_wr_idle();
    chk("led_10", 32'(led), 32'h10);
    push_r(32'h10, 2'b00, 1'b0);
    push_r(32'h11, 2'b00, 1'b0);
    push_r(32'h12, 2'b00, 1'b0);
    push_r(32'h13, 2'b00, 1'b1);
    issue_ar(32'h0, 4'd3);
    for (int i = 0; i < 4; i++) begin
      chk("burst_rvalid", 32'(bus.RVALID), 32'd1);
      chk("burst_arready", 32'(bus.ARREADY), 32'd0);
      tick();
    end
    chk("burst_done_rvalid", 32'(bus.RVALID), 32'd0);

    // Out of range write and read past the top
    write(32'h40, 32'hDEAD_BEEF, 4'hF, 2'b10);
    write(32'h3C, 32'h0000_0F15, 4'hF, 2'b00);
    wait_wr_idle();
    push_r(32'h10, 2'b00, 1'b1);
    issue_ar(32'h0, 4'd0);
    push_r(32'h0000_0F15, 2'b00, 1'b0);
    push_r(32'h0, 2'b10, 1'b1);
    issue_ar(32'h3C, 4'd1);
    wait_rd_idle();

    // Read backpressure while the same register is overwritten
    write(32'h14, 32'h55, 4'hF, 2'b00);
    wait_wr_idle();
    bus.RREADY = 1'b0;
    push_r(32'h55, 2'b00, 1'b1);
    issue_ar(32'h14, 4'd0);
    write(32'h14, 32'h66, 4'hF, 2'b00);
    for (int i = 0; i < 2; i++) begin
      chk("bp_rdata_hold", bus.RDATA, 32'h55);
      chk("bp_rvalid_hold", 32'(bus.RVALID), 32'd1);
      tick();
    end
    bus.RREADY = 1'b1;
    tick();
    push_r(32'h66, 2'b00, 1'b1);
    issue_ar(32'h14, 4'd0);
    wait_rd_idle();

    // Commit and read load on the same register at the same edge
    wait_wr_idle();
    bq.push_back(2'b00);
    push_r(32'h66, 2'b00, 1'b1);
    bus.AWADDR = 32'h14; bus.WDATA = 32'h77; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    bus.ARADDR = 32'h14; bus.BLEN = 4'd0; bus.ARVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    wait_rd_idle();
    push_r(32'h77, 2'b00, 1'b1);
    issue_ar(32'h14, 4'd0);
    wait_rd_idle();
    wait_wr_idle();

    // Reset during WR_WAIT_W and at beat 2 of a 4-beat burst
    bus.AWADDR = 32'h0; bus.AWVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0;
    chk("wwait_wready", 32'(bus.WREADY), 32'd1);
    chk("wwait_awready", 32'(bus.AWREADY), 32'd0);
    push_r(32'h10, 2'b00, 1'b0);
    push_r(32'h11, 2'b00, 1'b0);
    issue_ar(32'h0, 4'd3);
    tick();
    tick();
    ARESET = 1'b1;
    #1;
    chk_reset_outs("midrst");
    tick();
    ARESET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_bvalid", 32'(bus.BVALID), 32'd0);
      chk("post_rst_rvalid", 32'(bus.RVALID), 32'd0);
      tick();
    end
    push_r(32'h0, 2'b00, 1'b1);
    issue_ar(32'h0, 4'd0);
    wait_rd_idle();
    tick();

    chk("bq_drained", 32'(bq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
AXI-lite responder (slave) holding a small 32-bit register file, with full write-response (B) channel and BLEN-driven multi-beat reads with RLAST. Sits opposite axi_master_fsm on the shared ACLK/ARESET bus and replaces the current slave where B-channel completion and read-burst termination are required. Register 0 low LED_W bits drive the board LEDs.

Parameters:
NREG, 16, number of 32-bit registers; power of two, 2..16; word index = ADDR[2+log2(NREG)-1:2].
LED_W, 16, width of led output, taken from reg0[LED_W-1:0]; LED_W <= 32.

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  asynchronous active-high reset
AWADDR  in  32  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  32  write data
WSTRB  in  4  byte strobes, bit i enables WDATA[8i+7:8i]
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response, 2'b00 OKAY, 2'b10 SLVERR
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  32  read start address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
BLEN  in  4  read burst length, beats = BLEN+1 (1..16), sampled with AR handshake
RDATA  out  32  read data
RRESP  out  2  read response, same encoding as BRESP
RVALID  out  1  read data valid
RLAST  out  1  final beat of burst
RREADY  in  1  read data ready
led  out  LED_W  reg0[LED_W-1:0]

Behaviour:
- Reset (async, ARESET=1): all regs 0, write FSM WR_IDLE, read FSM RD_IDLE; AWREADY=1, WREADY=1, ARREADY=1, BVALID=0, BRESP=0, RVALID=0, RLAST=0, RRESP=0, RDATA=0, led=0. Reset mid-transaction aborts it; no response is issued for it.
- Address decode: in range iff ADDR[31:2] < NREG; ADDR[1:0] ignored. Out of range -> SLVERR.
- Write FSM, ready signals decoded from state:
  WR_IDLE: AWREADY=1, WREADY=1. AW and W in same cycle -> commit at that edge from bus values, go WR_RESP. AW only -> latch addr, go WR_WAIT_W. W only -> latch data+strb, go WR_WAIT_AW.
  WR_WAIT_W: AWREADY=0, WREADY=1; on W handshake commit, go WR_RESP.
  WR_WAIT_AW: AWREADY=1, WREADY=0; on AW handshake commit, go WR_RESP.
  WR_RESP: AWREADY=WREADY=0, BVALID=1, BRESP held stable; on BREADY go WR_IDLE. BVALID is first high the cycle after commit.
- Commit: per-byte update under WSTRB; WSTRB=0 -> no change, OKAY. Out of range -> no register change, SLVERR.
- Read FSM:
  RD_IDLE: ARREADY=1, RVALID=0. On AR handshake at edge T: idx<=ARADDR word index, beats_left<=BLEN, RDATA<=reg[idx], RVALID<=1, go RD_DATA. First beat is visible in cycle T+1.
  RD_DATA: ARREADY=0. RDATA/RRESP/RLAST are registered and stable while RVALID & !RREADY. RLAST=1 iff beats_left==0.
  On RVALID&RREADY: if RLAST, RVALID<=0, RLAST<=0, go RD_IDLE. Otherwise idx+1, beats_left-1, load next beat at the same edge (back-to-back, no bubble).
  Any beat whose index >= NREG (including bursts running past the top) -> RDATA=0, RRESP=SLVERR. Index does not wrap; the counter is wide enough to exceed NREG-1.
- Write and read FSMs are independent and run concurrently. If a commit and a read-data load hit the same register at the same edge, the read returns the pre-write value.
- led updates the cycle after a commit touching reg0.

Test Plan:
- Reset, then AW+W same cycle: AWADDR=0x0, WDATA=0x0000_A5A5, WSTRB=4'hF -> BVALID next cycle, BRESP=00, led=16'hA5A5.
- W two cycles before AW: WDATA=0x1234_5678 @0x8, WSTRB=4'b0101 over 0xFFFF_FFFF -> AWREADY=1/WREADY=0 while waiting, reg2=0xFF34_FF78, BRESP=00. Hold BREADY=0 for 3 cycles -> BVALID and BRESP stay stable.
- Burst read ARADDR=0x0, BLEN=3 with regs 0..3 preloaded 0x10,0x11,0x12,0x13, RREADY=1 -> 4 consecutive beats, RLAST only on 0x13, RRESP=00, ARREADY=0 throughout.
- Out of range: write 0x40 (NREG=16) -> BRESP=10, no register change. Read ARADDR=0x3C, BLEN=1 -> beat0 reg15 OKAY, beat1 RDATA=0, RRESP=10, RLAST=1.
- Backpressure plus collision: read reg5, RREADY=0 while a write to reg5 commits -> RDATA holds the old value until accepted; a following read returns the new value.
- Assert ARESET mid-burst (beat 2 of 4) and mid WR_WAIT_W -> all outputs at reset values immediately, led=0, no BVALID/RVALID after release.
